// File: rtl/vga_pkg.sv
// Shared timing defaults, control-bundle type and elaboration helpers for the VGA controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package vga_pkg;

    // 640x480@60 timing with a 25 MHz pixel clock
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Control bits that travel down the alignment pipeline together.
    // hsync/vsync are carried as pin levels (polarity already applied).
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic frame_start;
    } vga_ctl_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Pin level for a sync signal given its active polarity.
    function automatic logic sync_level(input logic pol, input logic is_asserted);
        return is_asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register; every stage resets asynchronously to RESET_VAL.
// Latency: DEPTH clocks from i_dat to o_dat.  Ports: clock, reset, i_dat[WIDTH], o_dat[WIDTH].
// Backpressure: none, shifts every clock.
module vga_delay_line #(
    parameter int                 WIDTH     = 1,
    parameter int                 DEPTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   i_dat,
    output logic [WIDTH-1:0]   o_dat
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
            end
        end else begin
            r_stage[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_scaled_controller.sv
// VGA timing generator with integer-downscaled framebuffer address fetch and read-latency compensation.
// Latency: pixel_address 1 clock after counter state; all VGA pins FETCH_LAT+2 clocks after it, mutually aligned.
// Backpressure: none, free-running.  Ports: clock/reset in; pixel_rgb+blank from source; pixel_address to source; vga_* + frame_start to pins.
module vga_scaled_controller
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   RGB_W     = 3,
    parameter int   SCALE     = 4,
    parameter int   ADDR_W    = 16,
    parameter int   FETCH_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [RGB_W-1:0]  pixel_rgb,
    input  logic              blank,
    output logic [ADDR_W-1:0] pixel_address,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_de,
    output logic [RGB_W-1:0]  vga_rgb,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FB_W    = H_ACTIVE / SCALE;
    localparam int FB_H    = V_ACTIVE / SCALE;
    localparam int PIPE    = FETCH_LAT + 2;

    localparam int H_W  = clog2(H_TOTAL);
    localparam int V_W  = clog2(V_TOTAL);
    localparam int HW1  = H_W + 1;
    localparam int VW1  = V_W + 1;
    localparam int SX_W = (clog2(SCALE) < 1) ? 1 : clog2(SCALE);
    // fb_x runs one past the last column at the end of an active line
    localparam int FX_W = clog2(FB_W + 1);

    localparam logic [H_W-1:0]    H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]    V_LAST   = V_W'(V_TOTAL - 1);
    // Region bounds compared one bit wider so an end bound equal to the total cannot wrap
    localparam logic [HW1-1:0]    H_ACT_C  = HW1'(H_ACTIVE);
    localparam logic [HW1-1:0]    HS_START = HW1'(H_ACTIVE + H_FP);
    localparam logic [HW1-1:0]    HS_END   = HW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW1-1:0]    V_ACT_C  = VW1'(V_ACTIVE);
    localparam logic [VW1-1:0]    VS_START = VW1'(V_ACTIVE + V_FP);
    localparam logic [VW1-1:0]    VS_END   = VW1'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SX_W-1:0]   S_LAST   = SX_W'(SCALE - 1);
    localparam logic [ADDR_W-1:0] FB_W_A   = ADDR_W'(FB_W);
    localparam vga_ctl_t          CTL_RST  = {~HSYNC_POL, ~VSYNC_POL, 1'b0, 1'b0};

    // Parameter sanity: stop elaboration on an unusable configuration
    if (SCALE < 1 || SCALE > 8) begin : g_err_scale
        $fatal(1, "vga_scaled_controller: SCALE must be 1..8");
    end
    if (FETCH_LAT < 0 || FETCH_LAT > 4) begin : g_err_lat
        $fatal(1, "vga_scaled_controller: FETCH_LAT must be 0..4");
    end
    if ((H_ACTIVE % SCALE) != 0 || (V_ACTIVE % SCALE) != 0) begin : g_err_div
        $fatal(1, "vga_scaled_controller: active area not divisible by SCALE");
    end
    if ((longint'(FB_W) * longint'(FB_H)) > (longint'(1) << ADDR_W)) begin : g_err_addr
        $fatal(1, "vga_scaled_controller: framebuffer does not fit in ADDR_W");
    end

    logic [H_W-1:0]    r_h_count;
    logic [V_W-1:0]    r_v_count;
    logic [SX_W-1:0]   r_sub_x;
    logic [SX_W-1:0]   r_sub_y;
    logic [FX_W-1:0]   r_fb_x;
    logic [ADDR_W-1:0] r_line_base;
    logic [ADDR_W-1:0] r_pixel_address;
    logic              r_vga_hsync;
    logic              r_vga_vsync;
    logic              r_vga_de;
    logic              r_frame_start;
    logic [RGB_W-1:0]  r_vga_rgb;

    logic [HW1-1:0]    w_h_ext;
    logic [VW1-1:0]    w_v_ext;
    logic              w_h_last;
    logic              w_frame_wrap;
    logic              w_v_active;
    logic              w_active;
    logic [ADDR_W-1:0] w_addr;
    vga_ctl_t          w_ctl_s0;
    vga_ctl_t          w_ctl_d;

    assign w_h_ext      = {1'b0, r_h_count};
    assign w_v_ext      = {1'b0, r_v_count};
    assign w_h_last     = (r_h_count == H_LAST);
    assign w_frame_wrap = w_h_last && (r_v_count == V_LAST);
    assign w_v_active   = (w_v_ext < V_ACT_C);
    assign w_active     = (w_h_ext < H_ACT_C) && w_v_active;
    assign w_addr       = r_line_base + ADDR_W'(r_fb_x);

    // Timing counters and the incremental address state (replaces (v/SCALE)*FB_W + h/SCALE)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_h_count       <= '0;
            r_v_count       <= '0;
            r_sub_x         <= '0;
            r_sub_y         <= '0;
            r_fb_x          <= '0;
            r_line_base     <= '0;
            r_pixel_address <= '0;
        end else begin
            if (w_h_last) begin
                r_h_count <= '0;
                r_v_count <= (r_v_count == V_LAST) ? '0 : r_v_count + 1'b1;
            end else begin
                r_h_count <= r_h_count + 1'b1;
            end

            // Frame wrap wins over the line wrap that coincides with it
            if (w_frame_wrap) begin
                r_sub_x     <= '0;
                r_sub_y     <= '0;
                r_fb_x      <= '0;
                r_line_base <= '0;
            end else if (w_h_last) begin
                r_sub_x <= '0;
                r_fb_x  <= '0;
                if (w_v_active) begin
                    if (r_sub_y == S_LAST) begin
                        r_sub_y     <= '0;
                        r_line_base <= r_line_base + FB_W_A;
                    end else begin
                        r_sub_y <= r_sub_y + 1'b1;
                    end
                end
            end else if (w_active) begin
                if (r_sub_x == S_LAST) begin
                    r_sub_x <= '0;
                    r_fb_x  <= r_fb_x + 1'b1;
                end else begin
                    r_sub_x <= r_sub_x + 1'b1;
                end
            end

            r_pixel_address <= w_active ? w_addr : '0;
        end
    end

    always_comb begin
        w_ctl_s0             = CTL_RST;
        w_ctl_s0.hsync       = sync_level(HSYNC_POL, (w_h_ext >= HS_START) && (w_h_ext < HS_END));
        w_ctl_s0.vsync       = sync_level(VSYNC_POL, (w_v_ext >= VS_START) && (w_v_ext < VS_END));
        w_ctl_s0.de          = w_active;
        w_ctl_s0.frame_start = (r_h_count == '0) && (r_v_count == '0);
    end

    // PIPE-1 stages here plus the output register below give PIPE in total; the
    // tap at PIPE-1 is the stage that lines up with pixel_rgb for the de/blank gate.
    vga_delay_line #(
        .WIDTH     ($bits(vga_ctl_t)),
        .DEPTH     (PIPE - 1),
        .RESET_VAL (CTL_RST)
    ) u_ctl_dly (
        .clock (clock),
        .reset (reset),
        .i_dat (w_ctl_s0),
        .o_dat (w_ctl_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vga_hsync   <= ~HSYNC_POL;
            r_vga_vsync   <= ~VSYNC_POL;
            r_vga_de      <= 1'b0;
            r_frame_start <= 1'b0;
            r_vga_rgb     <= '0;
        end else begin
            r_vga_hsync   <= w_ctl_d.hsync;
            r_vga_vsync   <= w_ctl_d.vsync;
            r_vga_de      <= w_ctl_d.de;
            r_frame_start <= w_ctl_d.frame_start;
            r_vga_rgb     <= (w_ctl_d.de && !blank) ? pixel_rgb : '0;
        end
    end

    assign pixel_address = r_pixel_address;
    assign vga_hsync     = r_vga_hsync;
    assign vga_vsync     = r_vga_vsync;
    assign vga_de        = r_vga_de;
    assign frame_start   = r_frame_start;
    assign vga_rgb       = r_vga_rgb;

endmodule

// File: tb/tb_vga_scaled_controller.sv
// Bench for vga_scaled_controller: two reduced-size instances (SCALE=4/FETCH_LAT=1 and SCALE=1/FETCH_LAT=0/active-high syncs).
// Outputs are compared every cycle with an arithmetic model of the raster, plus a table of hand-derived boundary points.
// Includes an asynchronous mid-frame reset and restart.
module tb_vga_scaled_controller;

    typedef struct packed {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
        int s;  int fl;
        bit hp; bit vp;
    } cfg_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [7:0]  rgb;
    } obs_t;

    typedef struct {
        int    dut;
        int    k;
        int    addr;
        bit    hs;
        bit    vs;
        bit    de;
        bit    fs;
        string name;
    } tv_t;

    localparam cfg_t CA = '{ha: 32, hfp: 4, hs: 6, hbp: 6, va: 16, vfp: 2, vs: 2, vbp: 3,
                            s: 4, fl: 1, hp: 1'b0, vp: 1'b0};
    localparam cfg_t CB = '{ha: 10, hfp: 2, hs: 2, hbp: 2, va: 6, vfp: 1, vs: 1, vbp: 1,
                            s: 1, fl: 0, hp: 1'b1, vp: 1'b1};

    logic       clock;
    logic       reset;
    logic       blank;
    logic [2:0] a_pix, b_pix;
    logic [7:0] a_addr;
    logic [5:0] b_addr;
    logic       a_hs, a_vs, a_de, a_fs;
    logic       b_hs, b_vs, b_de, b_fs;
    logic [2:0] a_rgb, b_rgb;

    int  n_vec;
    int  n_err;
    int  k;
    int  a_hist [4096];
    int  b_hist [4096];
    bit  bl_hist [4096];
    tv_t tbl [$];

    vga_scaled_controller #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .RGB_W(3), .SCALE(4), .ADDR_W(8), .FETCH_LAT(1)
    ) dut_a (
        .clock(clock), .reset(reset), .pixel_rgb(a_pix), .blank(blank),
        .pixel_address(a_addr), .vga_hsync(a_hs), .vga_vsync(a_vs), .vga_de(a_de),
        .vga_rgb(a_rgb), .frame_start(a_fs)
    );

    vga_scaled_controller #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .RGB_W(3), .SCALE(1), .ADDR_W(6), .FETCH_LAT(0)
    ) dut_b (
        .clock(clock), .reset(reset), .pixel_rgb(b_pix), .blank(blank),
        .pixel_address(b_addr), .vga_hsync(b_hs), .vga_vsync(b_vs), .vga_de(b_de),
        .vga_rgb(b_rgb), .frame_start(b_fs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model: raster position from elapsed cycles ----------------
    function automatic int htot(input cfg_t c);
        return c.ha + c.hfp + c.hs + c.hbp;
    endfunction

    function automatic int vtot(input cfg_t c);
        return c.va + c.vfp + c.vs + c.vbp;
    endfunction

    function automatic bit st_active(input cfg_t c, input int m);
        int h, v;
        if (m < 0) return 1'b0;
        h = m % htot(c);
        v = (m / htot(c)) % vtot(c);
        return (h < c.ha) && (v < c.va);
    endfunction

    function automatic int st_addr(input cfg_t c, input int m);
        int h, v;
        if (!st_active(c, m)) return 0;
        h = m % htot(c);
        v = (m / htot(c)) % vtot(c);
        return (v / c.s) * (c.ha / c.s) + h / c.s;
    endfunction

    // Content of the emulated frame RAM
    function automatic int src_pix(input int a);
        return (a ^ (a >> 3)) & 7;
    endfunction

    // Expected outputs at sample k (k = 0 is the first sample after reset release)
    function automatic obs_t expect_obs(input cfg_t c, input int kk, input bit blank_prev);
        obs_t o;
        int   m, h, v;
        bit   hs_on, vs_on;
        m      = kk - (c.fl + 2);
        o.addr = 32'(st_addr(c, kk - 1));
        if (m < 0) begin
            o.hs  = ~c.hp;
            o.vs  = ~c.vp;
            o.de  = 1'b0;
            o.fs  = 1'b0;
            o.rgb = 8'd0;
        end else begin
            h     = m % htot(c);
            v     = (m / htot(c)) % vtot(c);
            hs_on = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs);
            vs_on = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs);
            o.hs  = hs_on ? c.hp : ~c.hp;
            o.vs  = vs_on ? c.vp : ~c.vp;
            o.de  = st_active(c, m);
            o.fs  = (m % (htot(c) * vtot(c))) == 0;
            o.rgb = (o.de && !blank_prev) ? 8'(src_pix(st_addr(c, m))) : 8'd0;
        end
        return o;
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o.addr = 32'(a_addr);
        o.hs = a_hs; o.vs = a_vs; o.de = a_de; o.fs = a_fs;
        o.rgb = 8'(a_rgb);
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o.addr = 32'(b_addr);
        o.hs = b_hs; o.vs = b_vs; o.de = b_de; o.fs = b_fs;
        o.rgb = 8'(b_rgb);
        return o;
    endfunction

    task automatic check(input string name, input int kk, input obs_t got, input obs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d got{addr=%0d hs=%b vs=%b de=%b fs=%b rgb=%0d} want{addr=%0d hs=%b vs=%b de=%b fs=%b rgb=%0d}",
                     name, kk, got.addr, got.hs, got.vs, got.de, got.fs, got.rgb,
                     exp.addr, exp.hs, exp.vs, exp.de, exp.fs, exp.rgb);
        end
    endtask

    task automatic add_tv(input int dut, input int kk, input int addr,
                          input bit hs, input bit vs, input bit de, input bit fs, input string name);
        tv_t t;
        t.dut = dut; t.k = kk; t.addr = addr;
        t.hs = hs; t.vs = vs; t.de = de; t.fs = fs; t.name = name;
        tbl.push_back(t);
    endtask

    // One sample per falling edge: compare, then drive the next source data and blank.
    task automatic run(input int cycles, input bit use_tbl);
        for (int i = 0; i < cycles; i++) begin
            bit bp;
            bp = (k > 0) ? bl_hist[k-1] : 1'b0;
            check("a_model", k, obs_a(), expect_obs(CA, k, bp));
            check("b_model", k, obs_b(), expect_obs(CB, k, bp));
            if (use_tbl) begin
                foreach (tbl[j]) begin
                    if (tbl[j].k == k) begin
                        obs_t g;
                        g = (tbl[j].dut == 0) ? obs_a() : obs_b();
                        n_vec++;
                        if (g.addr !== 32'(tbl[j].addr) || g.hs !== tbl[j].hs || g.vs !== tbl[j].vs ||
                            g.de !== tbl[j].de || g.fs !== tbl[j].fs) begin
                            n_err++;
                            $display("FAIL %s k=%0d got{addr=%0d hs=%b vs=%b de=%b fs=%b} want{addr=%0d hs=%b vs=%b de=%b fs=%b}",
                                     tbl[j].name, k, g.addr, g.hs, g.vs, g.de, g.fs,
                                     tbl[j].addr, tbl[j].hs, tbl[j].vs, tbl[j].de, tbl[j].fs);
                        end
                    end
                end
            end
            a_hist[k] = int'(a_addr);
            b_hist[k] = int'(b_addr);
            // emulated RAM: data appears FETCH_LAT cycles after the address
            a_pix = 3'(src_pix((k >= 1) ? a_hist[k-1] : 0));
            b_pix = 3'(src_pix(b_hist[k]));
            blank = ($urandom_range(0, 3) == 0);
            bl_hist[k] = blank;
            k++;
            @(negedge clock);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        k     = 0;
        reset = 1'b1;
        blank = 1'b0;
        a_pix = 3'd0;
        b_pix = 3'd0;

        // Hand-derived boundary points.  A: 48x23 raster, PIPE=3, FB 8x4; syncs active low.
        add_tv(0,    0,  0, 1, 1, 0, 0, "a_release");
        add_tv(0,    1,  0, 1, 1, 0, 0, "a_first_addr");
        add_tv(0,    2,  0, 1, 1, 0, 0, "a_de_pre");
        add_tv(0,    3,  0, 1, 1, 1, 1, "a_de_rise");
        add_tv(0,    4,  0, 1, 1, 1, 0, "a_fs_off");
        add_tv(0,    5,  1, 1, 1, 1, 0, "a_fbx1");
        add_tv(0,   32,  7, 1, 1, 1, 0, "a_row_end");
        add_tv(0,   33,  0, 1, 1, 1, 0, "a_hblank");
        add_tv(0,   35,  0, 1, 1, 0, 0, "a_de_fall");
        add_tv(0,   38,  0, 1, 1, 0, 0, "a_hs_pre");
        add_tv(0,   39,  0, 0, 1, 0, 0, "a_hs_on");
        add_tv(0,   44,  0, 0, 1, 0, 0, "a_hs_last");
        add_tv(0,   45,  0, 1, 1, 0, 0, "a_hs_off");
        add_tv(0,  176,  7, 1, 1, 1, 0, "a_line3_end");
        add_tv(0,  193,  8, 1, 1, 0, 0, "a_line4");
        add_tv(0,  752, 31, 1, 1, 1, 0, "a_last_px");
        add_tv(0,  866,  0, 1, 1, 0, 0, "a_vs_pre");
        add_tv(0,  867,  0, 1, 0, 0, 0, "a_vs_on");
        add_tv(0,  962,  0, 1, 0, 0, 0, "a_vs_last");
        add_tv(0,  963,  0, 1, 1, 0, 0, "a_vs_off");
        add_tv(0, 1107,  0, 1, 1, 1, 1, "a_frame2");
        add_tv(0, 1109,  1, 1, 1, 1, 0, "a_frame2_x");
        // B: 16x9 raster, PIPE=2, SCALE=1; syncs active high.
        add_tv(1,    0,  0, 0, 0, 0, 0, "b_release");
        add_tv(1,    2,  1, 0, 0, 1, 1, "b_de_rise");
        add_tv(1,   10,  9, 0, 0, 1, 0, "b_addr9");
        add_tv(1,   11,  0, 0, 0, 1, 0, "b_hblank");
        add_tv(1,   14,  0, 1, 0, 0, 0, "b_hs_on");
        add_tv(1,   16,  0, 0, 0, 0, 0, "b_hs_off");
        add_tv(1,   18, 11, 0, 0, 1, 0, "b_line1");
        add_tv(1,   90, 59, 0, 0, 1, 0, "b_last_px");
        add_tv(1,  114,  0, 0, 1, 0, 0, "b_vs_on");
        add_tv(1,  130,  0, 0, 0, 0, 0, "b_vs_off");
        add_tv(1,  146,  1, 0, 0, 1, 1, "b_frame2");

        repeat (3) @(negedge clock);
        check("a_in_reset", 0, obs_a(), expect_obs(CA, 0, 1'b0));
        check("b_in_reset", 0, obs_b(), expect_obs(CB, 0, 1'b0));

        // Release between edges; two and a half frames of A, many frames of B
        reset = 1'b0;
        k = 0;
        run(2709, 1'b1);

        // Asynchronous reset mid-frame: outputs must clear before the next rising edge
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("a_async_rst", k, obs_a(), expect_obs(CA, 0, 1'b0));
        check("b_async_rst", k, obs_b(), expect_obs(CB, 0, 1'b0));
        repeat (2) @(negedge clock);
        reset = 1'b0;
        k = 0;
        run(400, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
